// File: rtl/calc_pkg.sv
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared calculator types, seven-segment glyphs and BCD decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

    localparam int NumDigits = 8;
    localparam int ExpBits   = $clog2(NumDigits);

    typedef logic [3:0] bcd_t;
    typedef logic [7:0] seg_t;

    typedef struct packed {
        bcd_t [NumDigits-1:0] significand;
        logic [ExpBits-1:0]   exponent;
    } num_t;

    // Segment bit order: bit0 = a ... bit6 = g, bit7 = dp; active-high.
    localparam seg_t SegBlank = 8'h00;
    localparam seg_t SegMinus = 8'h40;
    localparam seg_t SegE     = 8'h79;
    localparam seg_t SegR     = 8'h50;
    localparam seg_t SegDp    = 8'h80;

    function automatic seg_t bcd2segments(input bcd_t digit);
        seg_t seg;
        case (digit)
            4'd0:    seg = 8'h3F;
            4'd1:    seg = 8'h06;
            4'd2:    seg = 8'h5B;
            4'd3:    seg = 8'h4F;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'h6D;
            4'd6:    seg = 8'h7D;
            4'd7:    seg = 8'h07;
            4'd8:    seg = 8'h7F;
            4'd9:    seg = 8'h6F;
            default: seg = SegBlank;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/screen_scan_ctrl_scan_timer.sv
// ============================================================================
//  Module      : scan_timer
//  Description : Tick / digit / frame counters for a multiplexed display scan.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_timer #(
    parameter  int DigitTicks  = 1024,
    parameter  int NumDigits   = 8,
    parameter  int BlinkFrames = 64,
    localparam int TickW       = $clog2(DigitTicks),
    localparam int DigitW      = $clog2(NumDigits),
    localparam int FrameW      = $clog2(BlinkFrames)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [TickW-1:0]  tick_o,
    output logic [DigitW-1:0] digit_o,
    output logic [FrameW-1:0] frame_o,
    output logic              snap_o
);

    logic [TickW-1:0]  r_tick;
    logic [DigitW-1:0] r_digit;
    logic [FrameW-1:0] r_frame;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tick  <= '0;
            r_digit <= '0;
            r_frame <= '0;
        end else if (r_tick == TickW'(DigitTicks - 1)) begin
            r_tick <= '0;
            if (r_digit == DigitW'(NumDigits - 1)) begin
                r_digit <= '0;
                r_frame <= (r_frame == FrameW'(BlinkFrames - 1)) ? '0 : r_frame + 1'b1;
            end else begin
                r_digit <= r_digit + 1'b1;
            end
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    assign tick_o  = r_tick;
    assign digit_o = r_digit;
    assign frame_o = r_frame;
    assign snap_o  = (r_tick == '0) && (r_digit == '0);

endmodule

`default_nettype wire

// File: rtl/screen_scan_ctrl.sv
// ============================================================================
//  Module      : screen_scan_ctrl
//  Description : Number formatter and common-anode multiplexed 7-seg scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module screen_scan_ctrl
    import calc_pkg::*;
#(
    parameter  int NumDigits   = calc_pkg::NumDigits,
    parameter  int DigitTicks  = 1024,
    parameter  int BrightBits  = 3,
    parameter  int GuardTicks  = 2,
    parameter  int BlinkFrames = 64,
    localparam int SelW        = $clog2(NumDigits),
    localparam int TickW       = $clog2(DigitTicks),
    localparam int FrameW      = $clog2(BlinkFrames)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  num_t                  num_i,
    input  logic                  neg_i,
    input  logic                  error_i,
    input  logic                  override_shift_i,
    input  logic [SelW-1:0]       shift_amount_i,
    input  logic [BrightBits-1:0] brightness_i,
    input  logic                  blink_i,
    output seg_t [NumDigits-1:0]  display_segments_o,
    output logic [7:0]            segments_cathode_o,
    output logic [NumDigits-1:0]  segments_anode_o,
    output logic                  frame_o
);

    logic [TickW-1:0]     w_tick;
    logic [SelW-1:0]      w_digit;
    logic [FrameW-1:0]    w_frame;
    logic                 w_snap;
    seg_t [NumDigits-1:0] w_fmt;
    logic [NumDigits-1:0] w_anode;
    logic                 w_lit;
    logic                 w_on;

    seg_t [NumDigits-1:0] r_segs;
    logic [7:0]           r_cath;
    logic [NumDigits-1:0] r_anode;
    logic                 r_frame;

    scan_timer #(
        .DigitTicks  (DigitTicks),
        .NumDigits   (NumDigits),
        .BlinkFrames (BlinkFrames)
    ) u_scan_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .tick_o  (w_tick),
        .digit_o (w_digit),
        .frame_o (w_frame),
        .snap_o  (w_snap)
    );

    always_comb begin
        int   frac;
        int   shift;
        int   dp_pos;
        int   msd;
        int   top;
        int   src;
        int   minus_pos;
        logic found;
        logic overflow;

        w_fmt  = '0;
        frac   = NumDigits - 1 - int'(num_i.exponent);
        shift  = frac;
        found  = 1'b0;
        for (int i = 0; i < NumDigits; i++) begin
            if (!found && (i < frac) && (num_i.significand[i] != '0)) begin
                shift = i;
                found = 1'b1;
            end
        end
        if (override_shift_i) begin
            shift = int'(shift_amount_i);
        end
        dp_pos = frac - shift;

        msd = -1;
        src = 0;
        for (int d = 0; d < NumDigits; d++) begin
            src = d + shift;
            if (src <= NumDigits - 1) begin
                w_fmt[d] = bcd2segments(num_i.significand[src[SelW-1:0]]);
                if (num_i.significand[src[SelW-1:0]] != '0) begin
                    msd = d;
                end
            end
        end

        // Leading zeros are kept down to the dp digit so fractions read "0.05".
        top = (msd > dp_pos) ? msd : dp_pos;
        for (int d = 0; d < NumDigits; d++) begin
            if (d > top) begin
                w_fmt[d] = SegBlank;
            end
        end
        if ((dp_pos >= 0) && (dp_pos < NumDigits)) begin
            w_fmt[dp_pos[SelW-1:0]] = w_fmt[dp_pos[SelW-1:0]] | SegDp;
        end

        overflow  = neg_i && (top >= NumDigits - 1);
        minus_pos = top + 1;
        if (neg_i && !overflow) begin
            w_fmt[minus_pos[SelW-1:0]] = SegMinus;
        end

        if (error_i || overflow) begin
            w_fmt = '0;
            for (int d = 0; d < NumDigits; d++) begin
                if (d == NumDigits - 1) begin
                    w_fmt[d] = SegE;
                end else if (d >= NumDigits - 3) begin
                    w_fmt[d] = SegR;
                end
            end
        end
    end

    assign w_lit = !(blink_i && (w_frame >= FrameW'(BlinkFrames / 2)));
    assign w_on  = (w_tick >= TickW'(GuardTicks)) && w_lit &&
                   ((brightness_i == '1) || (w_tick[TickW-1 -: BrightBits] < brightness_i));

    always_comb begin
        w_anode = '1;
        if (w_on) begin
            w_anode[w_digit] = 1'b0;
        end
    end

    // The snapshot loads in the frame_o cycle so a whole frame scans one stable image.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_frame <= 1'b0;
            r_segs  <= '0;
            r_cath  <= '1;
            r_anode <= '1;
        end else begin
            r_frame <= w_snap;
            if (r_frame) begin
                r_segs <= w_fmt;
            end
            r_cath  <= ~r_segs[w_digit];
            r_anode <= w_anode;
        end
    end

    assign display_segments_o = r_segs;
    assign segments_cathode_o = r_cath;
    assign segments_anode_o   = r_anode;
    assign frame_o            = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_screen_scan_ctrl.sv
// ============================================================================
//  Module      : tb_screen_scan_ctrl
//  Description : Directed self-checking bench for screen_scan_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_screen_scan_ctrl;
    import calc_pkg::*;

    localparam int c_ND = 8;
    localparam int c_DT = 16;
    localparam int c_FRAME_CYCLES = c_ND * c_DT;

    // Expected snapshots, digit 7 in the top byte.
    localparam logic [63:0] c_SEGS_0 = 64'h00000000_00000000;
    localparam logic [63:0] c_SEGS_A = 64'h00000000_0006DB6D;
    localparam logic [63:0] c_SEGS_B = 64'h00004006_5B4F66ED;
    localparam logic [63:0] c_SEGS_C = 64'h79505000_00000000;
    localparam logic [63:0] c_SEGS_E = 64'h00000000_000000EF;
    localparam logic [63:0] c_SEGS_F = 64'h00000006_DB6D3F3F;

    logic                clk = 1'b0;
    logic                rst;
    num_t                num;
    logic                neg;
    logic                err;
    logic                ovr;
    logic [2:0]          shamt;
    logic [1:0]          bright;
    logic                blink;
    seg_t [c_ND-1:0]     disp;
    logic [7:0]          cath;
    logic [c_ND-1:0]     anode;
    logic                frame;

    int checks   = 0;
    int failures = 0;
    int fr       = 0;

    always #5 clk = ~clk;

    screen_scan_ctrl #(
        .NumDigits   (8),
        .DigitTicks  (16),
        .BrightBits  (2),
        .GuardTicks  (2),
        .BlinkFrames (4)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .num_i              (num),
        .neg_i              (neg),
        .error_i            (err),
        .override_shift_i   (ovr),
        .shift_amount_i     (shamt),
        .brightness_i       (bright),
        .blink_i            (blink),
        .display_segments_o (disp),
        .segments_cathode_o (cath),
        .segments_anode_o   (anode),
        .frame_o            (frame)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_anode(input int j, input int br, input bit lit);
        logic [7:0] a;
        int d;
        int t;
        a = 8'hFF;
        d = j / c_DT;
        t = j % c_DT;
        if ((t >= 2) && lit && ((br == 3) || ((t / 4) < br))) begin
            a[d] = 1'b0;
        end
        return a;
    endfunction

    function automatic logic [7:0] seg_of(input logic [63:0] segs, input int d);
        return segs[8*d +: 8];
    endfunction

    // Called at the negedge of a frame_o cycle; returns at the next one.
    // Iteration j sits in the cycle whose anode/cathode reflect scan position j.
    task automatic check_frame(input logic [63:0] exp_segs, input logic [63:0] prev_segs,
                               input int br, input int chg_at,
                               input logic [31:0] chg_sig, input logic [2:0] chg_exp);
        bit lit;
        lit = !(blink && ((fr % 4) >= 2));
        chk("frame_pulse", {63'd0, frame}, 64'd1);
        for (int j = 0; j < c_FRAME_CYCLES; j++) begin
            if (j > 0) chk("frame_idle", {63'd0, frame}, 64'd0);
            chk("anode", {56'd0, anode}, {56'd0, exp_anode(j, br, lit)});
            if (j == 0) chk("display_prev", disp, prev_segs);
            else        chk("display", disp, exp_segs);
            if (j < 2) chk("cathode_prev", {56'd0, cath}, {56'd0, ~seg_of(prev_segs, 0)});
            else       chk("cathode", {56'd0, cath}, {56'd0, ~seg_of(exp_segs, j / c_DT)});
            if (j == chg_at) begin
                num.significand = chg_sig;
                num.exponent    = chg_exp;
            end
            @(negedge clk);
        end
        fr++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_anode"},   {56'd0, anode}, 64'h0000_0000_0000_00FF);
        chk({tag, "_cathode"}, {56'd0, cath},  64'h0000_0000_0000_00FF);
        chk({tag, "_frame"},   {63'd0, frame}, 64'd0);
        chk({tag, "_display"}, disp,           c_SEGS_0);
    endtask

    initial begin
        rst             = 1'b1;
        num.significand = 32'h00012500;
        num.exponent    = 3'd4;
        neg             = 1'b0;
        err             = 1'b0;
        ovr             = 1'b0;
        shamt           = 3'd0;
        bright          = 2'd3;
        blink           = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        chk("release_frame", {63'd0, frame}, 64'd0);
        @(negedge clk);

        // 00012500 exp 4: shift 2, dp on digit 1.
        check_frame(c_SEGS_A, c_SEGS_0, 3, -1, 32'h0, 3'd0);
        bright = 2'd1;
        check_frame(c_SEGS_A, c_SEGS_A, 1, -1, 32'h0, 3'd0);
        bright = 2'd0;
        check_frame(c_SEGS_A, c_SEGS_A, 0, -1, 32'h0, 3'd0);

        bright          = 2'd3;
        neg             = 1'b1;
        num.significand = 32'h00012345;
        num.exponent    = 3'd7;
        check_frame(c_SEGS_B, c_SEGS_A, 3, -1, 32'h0, 3'd0);

        num.significand = 32'h87654321;
        check_frame(c_SEGS_C, c_SEGS_B, 3, -1, 32'h0, 3'd0);

        // Input change at tick 5 of digit 3 must not tear the current frame.
        neg             = 1'b0;
        num.significand = 32'h00012500;
        num.exponent    = 3'd4;
        check_frame(c_SEGS_A, c_SEGS_C, 3, 3 * c_DT + 5 - 1, 32'h00000009, 3'd7);
        check_frame(c_SEGS_E, c_SEGS_A, 3, -1, 32'h0, 3'd0);

        num.significand = 32'h00012500;
        num.exponent    = 3'd4;
        ovr             = 1'b1;
        shamt           = 3'd0;
        check_frame(c_SEGS_F, c_SEGS_E, 3, -1, 32'h0, 3'd0);

        ovr = 1'b0;
        err = 1'b1;
        check_frame(c_SEGS_C, c_SEGS_F, 3, -1, 32'h0, 3'd0);

        err   = 1'b0;
        blink = 1'b1;
        check_frame(c_SEGS_A, c_SEGS_C, 3, -1, 32'h0, 3'd0);
        check_frame(c_SEGS_A, c_SEGS_A, 3, -1, 32'h0, 3'd0);
        check_frame(c_SEGS_A, c_SEGS_A, 3, -1, 32'h0, 3'd0);

        // Frame 0 of the blink period: lit, then reset lands mid-digit.
        chk("blink_frame_pulse", {63'd0, frame}, 64'd1);
        repeat (39) @(negedge clk);
        chk("pre_reset_anode", {56'd0, anode}, 64'h0000_0000_0000_00FB);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rerelease_frame", {63'd0, frame}, 64'd0);
        @(negedge clk);
        fr = 0;
        check_frame(c_SEGS_A, c_SEGS_0, 3, -1, 32'h0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
